// File: rtl/box_shrink_pkg.sv
// box_shrink_pkg: shared FSM states and derived-size helpers for box_shrink
package box_shrink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    function automatic int out_w(input int width, input int fx);
        return width / fx;
    endfunction

    function automatic int out_h(input int height, input int fy);
        return height / fy;
    endfunction

    function automatic int acc_w(input int dw, input int fx, input int fy);
        return dw + $clog2(fx * fy);
    endfunction

endpackage

// File: rtl/box_accum.sv
// box_accum: one channel's block accumulator with reload-on-first and divide-by-block-size
module box_accum
    import box_shrink_pkg::*;
#(
    parameter int DW = 8,
    parameter int FX = 2,
    parameter int FY = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_first,
    input  logic [DW-1:0] i_pix,
    output logic [DW-1:0] o_avg
);

    localparam int N  = FX * FY;
    localparam int SW = acc_w(DW, FX, FY);

    logic [SW-1:0] r_acc;
    logic [SW-1:0] w_sum;

    assign w_sum = (i_first ? '0 : r_acc) + SW'(i_pix);

    if ((N & (N - 1)) == 0) begin : g_shift
        assign o_avg = DW'(w_sum >> $clog2(N));
    end else begin : g_div
        assign o_avg = DW'(w_sum / SW'(N));
    end

    // Running sum; the first pixel of a block replaces the previous block's total
    always_ff @(posedge clk) r_acc <= rst ? '0 : i_en ? w_sum : r_acc;

endmodule

// File: rtl/box_shrink.sv
// box_shrink: streaming frame shrink by FX x FY; decimates by default,
// box-averages each block when BOX_SHRINK_AVG_EN is defined
module box_shrink
    import box_shrink_pkg::*;
#(
    parameter int FX     = 2,
    parameter int FY     = 2,
    parameter int CH     = 3,
    parameter int DW     = 8,
    parameter int WIDTH  = 30,
    parameter int HEIGHT = 30,
    localparam int AW    = $clog2(WIDTH * HEIGHT)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [CH*DW-1:0] pix_in,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [CH*DW-1:0] pix_out
);

    localparam int OW = out_w(WIDTH, FX);
    localparam int OH = out_h(HEIGHT, FY);
    localparam int CW = $clog2((WIDTH > HEIGHT ? WIDTH : HEIGHT) + 1);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_ox, r_oy, w_bx, w_by;
    logic            w_blk_last, w_last_rd;
    logic            r_v1, r_last1;
    logic [CH*DW-1:0] w_avg;

`ifdef BOX_SHRINK_AVG_EN
    logic [CW-1:0] r_bx, r_by;
    logic          r_first1;

    assign w_bx       = r_bx;
    assign w_by       = r_by;
    assign w_blk_last = (r_bx == CW'(FX - 1)) && (r_by == CW'(FY - 1));

    // Walk each block row by row before the block counters advance
    always_ff @(posedge clk) begin
        if (rst || r_state != RUN) begin
            r_bx <= '0;
            r_by <= '0;
        end else begin
            r_bx <= (r_bx == CW'(FX - 1)) ? '0 : r_bx + 1'b1;
            r_by <= (r_bx != CW'(FX - 1)) ? r_by : (r_by == CW'(FY - 1)) ? '0 : r_by + 1'b1;
        end
    end

    // Mark the first pixel of a block so it arrives with a reload flag
    always_ff @(posedge clk) r_first1 <= rst ? 1'b0 : (r_state == RUN) && r_bx == '0 && r_by == '0;

    for (genvar c = 0; c < CH; c++) begin : g_acc
        box_accum #(.DW(DW), .FX(FX), .FY(FY)) u_acc (
            .clk    (clk),
            .rst    (rst),
            .i_en   (r_v1),
            .i_first(r_first1),
            .i_pix  (pix_in[c*DW +: DW]),
            .o_avg  (w_avg[c*DW +: DW])
        );
    end
`else
    assign w_bx       = '0;
    assign w_by       = '0;
    assign w_blk_last = 1'b1;
    assign w_avg      = pix_in;
`endif

    assign w_last_rd = w_blk_last && r_ox == CW'(OW - 1) && r_oy == CW'(OH - 1);
    assign rd_en     = r_state == RUN;
    assign rd_addr   = AW'((r_oy * FY + w_by) * WIDTH + r_ox * FX + w_bx);
    assign busy      = r_state == RUN || r_state == FLUSH;
    assign done      = r_state == DONE;

    // Output block position, stepped once per completed block, idle at zero
    always_ff @(posedge clk) begin
        if (rst || r_state != RUN) begin
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_blk_last) begin
            r_ox <= (r_ox == CW'(OW - 1)) ? '0 : r_ox + 1'b1;
            r_oy <= (r_ox != CW'(OW - 1)) ? r_oy : (r_oy == CW'(OH - 1)) ? '0 : r_oy + 1'b1;
        end
    end

    // Delay the read strobe to line up with pixel data returning from memory
    always_ff @(posedge clk) begin
        r_v1    <= rst ? 1'b0 : rd_en;
        r_last1 <= rst ? 1'b0 : rd_en && w_blk_last;
    end

    // Register each finished output pixel; destination address steps after every write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            pix_out <= '0;
        end else begin
            wr_en   <= r_last1;
            wr_addr <= (r_state == IDLE) ? '0 : wr_en ? wr_addr + 1'b1 : wr_addr;
            pix_out <= r_last1 ? w_avg : pix_out;
        end
    end

    // Next state: start only matters in IDLE, FLUSH waits for the pipeline to drain
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last_rd ? FLUSH : RUN;
            FLUSH:   w_next = (wr_en && !r_v1) ? DONE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

endmodule

// File: tb/tb_box_shrink.sv
// tb_box_shrink: four box_shrink configurations checked every cycle against a frame-level model
module tb_box_shrink;

`ifdef BOX_SHRINK_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, prep_req = 1'b0, rst_q = 1'b1;
    int   mode = 0, n_pass = 0, n_total = 0;
    int   dec0[4]  = '{0, 2, 8, 10};
    int   avg0[4]  = '{2, 4, 10, 12};
    int   rd0a[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int   rd1a[8]  = '{0, 1, 5, 6, 2, 3, 7, 8};
    int   rd1d[2]  = '{0, 2};

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int W   = g == 3 ? 7 : g == 1 ? 5 : 4;
        localparam int H   = g == 3 ? 5 : g == 1 ? 3 : 4;
        localparam int FXg = g == 3 ? 3 : g == 2 ? 1 : 2;
        localparam int FYg = g == 2 ? 1 : 2;
        localparam int AWg = $clog2(W * H);
        localparam int NB  = AVG ? FXg * FYg : 1;
        localparam int NW  = (W / FXg) * (H / FYg);
        localparam int NR  = NW * NB;

        logic             busy, done, rd_en, wr_en;
        logic [AWg-1:0]   rd_addr, wr_addr;
        logic [23:0]      pix_in, pix_out;
        logic [23:0]      src[W*H];
        logic [23:0]      got[NW];
        logic [23:0]      exp_pix[NW];
        int               exp_rd[NR];
        int               rd_log[NR];
        int               rd_idx = 0, wr_idx = 0;
        bit               armed = 0, done_seen = 0, fr1 = 0, fr2 = 0, lastw = 0;

        box_shrink #(.FX(FXg), .FY(FYg), .CH(3), .DW(8), .WIDTH(W), .HEIGHT(H)) dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .busy   (busy),
            .done   (done),
            .rd_en  (rd_en),
            .rd_addr(rd_addr),
            .pix_in (pix_in),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .pix_out(pix_out)
        );

        always @(posedge clk) pix_in <= rd_en ? src[rd_addr] : 24'($urandom);

        always @(negedge clk) begin
            int s[3];
            int a, k;
            bit fin, done_exp;
            fin = 0;
            if (rst_q) begin
                chk($sformatf("u%0d_reset_zero", g),
                    64'({busy, done, rd_en, wr_en, rd_addr, wr_addr, pix_out}), 64'd0);
                armed = 0; rd_idx = 0; wr_idx = 0; fr1 = 0; fr2 = 0; lastw = 0;
            end else begin
                if (prep_req) begin
                    for (int y = 0; y < H; y++)
                        for (int x = 0; x < W; x++)
                            src[y*W+x] = mode == 1 ? {3{8'(y*W+x)}} : mode == 2 ? 24'hFFFFFF : 24'($urandom);
                    k = 0;
                    for (int oy = 0; oy < H / FYg; oy++)
                        for (int ox = 0; ox < W / FXg; ox++) begin
                            s = '{0, 0, 0};
                            for (int by = 0; by < (AVG ? FYg : 1); by++)
                                for (int bx = 0; bx < (AVG ? FXg : 1); bx++) begin
                                    a = (oy * FYg + by) * W + ox * FXg + bx;
                                    exp_rd[k] = a;
                                    k++;
                                    for (int c = 0; c < 3; c++) s[c] += int'(src[a][c*8 +: 8]);
                                end
                            for (int c = 0; c < 3; c++) exp_pix[oy*(W/FXg)+ox][c*8 +: 8] = 8'(s[c] / NB);
                        end
                    rd_idx = 0; wr_idx = 0; armed = 1; done_seen = 0;
                end
                if (armed && rd_idx > 0 && rd_idx < NR)
                    chk($sformatf("u%0d_rd_no_bubble", g), rd_en, 1);
                if (rd_en) begin
                    chk($sformatf("u%0d_rd_expected", g), 64'(armed && rd_idx < NR), 1);
                    chk($sformatf("u%0d_busy_in_rd", g), busy, 1);
                    if (armed && rd_idx < NR) begin
                        chk($sformatf("u%0d_rd_addr%0d", g, rd_idx), rd_addr, exp_rd[rd_idx]);
                        rd_log[rd_idx] = int'(rd_addr);
                        fin = (rd_idx % NB) == NB - 1;
                        rd_idx++;
                    end
                end
                if (wr_en || fr2) chk($sformatf("u%0d_wr_timing", g), wr_en, fr2);
                if (wr_en) begin
                    chk($sformatf("u%0d_wr_expected", g), 64'(wr_idx < NW), 1);
                    if (wr_idx < NW) begin
                        chk($sformatf("u%0d_wr_addr%0d", g, wr_idx), wr_addr, wr_idx);
                        chk($sformatf("u%0d_pix%0d", g, wr_idx), pix_out, exp_pix[wr_idx]);
                        got[wr_idx] = pix_out;
                    end
                    wr_idx++;
                end
                done_exp = lastw;
                lastw = wr_en && wr_idx == NW;
                if (done || done_exp) chk($sformatf("u%0d_done_pulse", g), done, done_exp);
                if (done) begin
                    chk($sformatf("u%0d_busy_in_done", g), busy, 0);
                    chk($sformatf("u%0d_rd_total", g), rd_idx, NR);
                    done_seen = 1;
                    armed = 0;
                end
                fr2 = fr1;
                fr1 = fin;
            end
        end
    end

    task automatic run_frame(input int m, input bit dbl, input bit abort);
        int k;
        @(negedge clk); #1 mode = m; prep_req = 1'b1;
        @(negedge clk); #1 prep_req = 1'b0; start = 1'b1;
        @(negedge clk); #1 start = dbl;
        @(negedge clk); #1 start = 1'b0;
        if (abort) begin
            rst = 1'b1;
            @(negedge clk); #1 rst = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            k = 0;
            while (!(u[0].done_seen && u[1].done_seen && u[2].done_seen && u[3].done_seen) && k < 600) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("frame_mode%0d_complete", m),
                64'(u[0].done_seen && u[1].done_seen && u[2].done_seen && u[3].done_seen), 1);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        run_frame(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u0_model_pix%0d", i), u[0].exp_pix[i], {3{8'(AVG ? avg0[i] : dec0[i])}});
            chk($sformatf("u0_lit_pix%0d", i), u[0].got[i], {3{8'(AVG ? avg0[i] : dec0[i])}});
        end
        for (int i = 0; i < (AVG ? 16 : 4); i++)
            chk($sformatf("u0_lit_rd%0d", i), u[0].rd_log[i], AVG ? rd0a[i] : dec0[i]);
        chk("u0_lit_writes", u[0].wr_idx, 4);
        chk("u1_lit_writes", u[1].wr_idx, 2);
        for (int i = 0; i < (AVG ? 8 : 2); i++)
            chk($sformatf("u1_lit_rd%0d", i), u[1].rd_log[i], AVG ? rd1a[i] : rd1d[i]);
        for (int i = 0; i < 16; i++)
            chk($sformatf("u2_copy%0d", i), u[2].got[i], u[2].src[i]);
        run_frame(2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("u3_sat_pix%0d", i), u[3].got[i], 24'hFFFFFF);
        run_frame(0, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++) run_frame(0, f[0], 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
